matmul_operand_loader: RTL

Streaming front end for `matrix_multiplication_accumulation`. It accepts one element per cycle over a valid/ready stream and assembles the operands A[M][K], B[K][N] and C[M][N] in registers. It presents the complete, stable operand set to the combinational multiplier and holds it until the downstream stage acknowledges. It then reloads the next frame.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/mm_index_counter.sv | 55 +++++
 rtl/matmul_operand_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul operand loader.
package matmul_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      LOAD_C = 2'd2,
      FULL   = 2'd3
   } loader_state_t;

   // Index width that stays at least one bit even for a single-entry dimension.
   function automatic int idx_w(input int x);
      return (x > 2) ? $clog2(x) : 1;
   endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Row/column wrap counter with bounds supplied at run time.
// last is high while the counter sits on the final (row_max, col_max) position.
module mm_index_counter
   import matmul_pkg::*;
#(
   parameter int ROWS = 2,
   parameter int COLS = 2,
   localparam int RW = idx_w(ROWS),
   localparam int CW = idx_w(COLS)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic [RW-1:0] row_max,
   input  logic [CW-1:0] col_max,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (inc) begin
         if (col_q == col_max) begin
            col_d = '0;
            row_d = (row_q == row_max) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign last = (row_q == row_max) && (col_q == col_max);

endmodule

// File: rtl/matmul_operand_loader.sv
// Streams A, B, then C (row-major) into operand registers and holds the full set for the multiplier.
// Accepts one element per cycle while loading; in_ready is low only in FULL, until out_ready.
module matmul_operand_loader
   import matmul_pkg::*;
#(
   parameter int M = 2,
   parameter int N = 2,
   parameter int K = 2,
   parameter int P = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*P-1:0]        in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic signed [P-1:0]   A [M][K],
   output logic signed [P-1:0]   B [K][N],
   output logic signed [4*P-1:0] C [M][N],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err
);

   localparam int R_MAX = (M > K) ? M : K;
   localparam int C_MAX = (K > N) ? K : N;
   localparam int RW    = idx_w(R_MAX);
   localparam int CW    = idx_w(C_MAX);
   localparam int MW    = idx_w(M);
   localparam int KW    = idx_w(K);
   localparam int NW    = idx_w(N);

   loader_state_t state_q, state_d, next_phase;
   logic          err_q, err_d;

   logic signed [P-1:0]   a_q [M][K];
   logic signed [P-1:0]   a_d [M][K];
   logic signed [P-1:0]   b_q [K][N];
   logic signed [P-1:0]   b_d [K][N];
   logic signed [4*P-1:0] c_q [M][N];
   logic signed [4*P-1:0] c_d [M][N];

   logic          accept;
   logic          frame_end;
   logic          cnt_clr, cnt_inc;
   logic [RW-1:0] row, row_max;
   logic [CW-1:0] col, col_max;
   logic          idx_last;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q == FULL);
   assign accept    = in_valid && in_ready;
   assign err       = err_q;
   assign A         = a_q;
   assign B         = b_q;
   assign C         = c_q;

   // The one index counter is re-bounded to the shape of whichever operand is loading.
   always_comb begin
      row_max = RW'(M - 1);
      col_max = CW'(K - 1);
      case (state_q)
         LOAD_B: begin
            row_max = RW'(K - 1);
            col_max = CW'(N - 1);
         end
         LOAD_C: begin
            row_max = RW'(M - 1);
            col_max = CW'(N - 1);
         end
         default: ;
      endcase
   end

   mm_index_counter #(
      .ROWS (R_MAX),
      .COLS (C_MAX)
   ) u_idx (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .row_max (row_max),
      .col_max (col_max),
      .row     (row),
      .col     (col),
      .last    (idx_last)
   );

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      next_phase = LOAD_A;
      frame_end  = 1'b0;
      if (state_q == FULL) begin
         if (out_ready) state_d = LOAD_A;
      end else if (accept) begin
         case (state_q)
            LOAD_A: begin
               a_d[MW'(row)][KW'(col)] = $signed(in_data[P-1:0]);
               next_phase = LOAD_B;
            end
            LOAD_B: begin
               b_d[KW'(row)][NW'(col)] = $signed(in_data[P-1:0]);
               next_phase = LOAD_C;
            end
            default: begin
               c_d[MW'(row)][NW'(col)] = $signed(in_data);
               next_phase = FULL;
            end
         endcase
         // in_last must coincide exactly with C[M-1][N-1]; any other pairing aborts the frame.
         frame_end = (state_q == LOAD_C) && idx_last;
         if (in_last != frame_end) begin
            err_d   = 1'b1;
            state_d = LOAD_A;
            cnt_clr = 1'b1;
         end else if (idx_last) begin
            state_d = next_phase;
            cnt_clr = 1'b1;
         end else begin
            cnt_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD_A;
         err_q   <= 1'b0;
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         c_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end

endmodule
